// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Issues sequential word fetches
// over a request/response memory port, buffers returned {pc, inst} pairs in
// an in-order FIFO for decode, and handles redirects by discarding any
// responses still in flight when the redirect happens.
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);   // counter width, holds 0..DEPTH
    localparam int PW = $clog2(DEPTH);       // FIFO pointer width, wraps naturally

    // Registered state
    logic            rst_n_q;
    logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,     resp_pc_d;
    logic [CW-1:0]   occupancy_q,   occupancy_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q,    drop_cnt_d;
    logic [PW-1:0]   wr_ptr_q,      wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,      rd_ptr_d;

    // FIFO storage
    logic [XLEN-1:0] mem_pc_q   [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];

    // Per-cycle events
    logic [CW:0]     in_use;
    logic            credit_ok;
    logic            req_fire;
    logic            resp_drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] flush_target;

    // The two low bits of a redirect target are always forced to zero.
    logic            unused_flush_lsbs;
    assign unused_flush_lsbs = ^flush_pc[1:0];
    assign flush_target      = {flush_pc[XLEN-1:2], 2'b00};

    // Credit: buffered plus in-flight words may never exceed the FIFO size,
    // so every response that comes back is guaranteed a free slot.
    assign in_use    = {1'b0, occupancy_q} + {1'b0, outstanding_q};
    assign credit_ok = in_use < (CW+1)'(DEPTH);

    assign imem_req_valid = rst_n_q & ~flush & credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response belonging to a pre-redirect request is discarded.
    assign resp_drop = imem_resp_valid & (drop_cnt_q != '0);
    assign push      = imem_resp_valid & ~resp_drop & ~flush;

    assign inst_valid = occupancy_q != '0;
    assign pop        = inst_valid & inst_ready & ~flush;

    // Head is masked while empty so stale slots never become visible.
    assign inst_data = inst_valid ? mem_data_q[rd_ptr_q] : '0;
    assign inst_pc   = inst_valid ? mem_pc_q[rd_ptr_q]   : '0;

    // Next-state logic: flush overrides every other event in the cycle
    always_comb begin
        // NOTE: every _d gets a default from its _q first, so no path through
        // this block can leave a variable unassigned and infer a latch.
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        occupancy_d   = occupancy_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (flush) begin
            fetch_pc_d    = flush_target;
            resp_pc_d     = flush_target;
            occupancy_d   = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            // Everything still in flight (excluding this cycle's response,
            // which is discarded right now) must be dropped on return.
            outstanding_d = outstanding_q - CW'(imem_resp_valid);
            drop_cnt_d    = outstanding_q - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            occupancy_d = occupancy_q + CW'(push) - CW'(pop);
        end
    end

    // Control and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, independent of statement order.
        if (!rst_n) begin
            rst_n_q       <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            occupancy_q   <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            rst_n_q       <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            occupancy_q   <= occupancy_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage write on accepted response
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; occupancy gates visibility,
        // so clearing the array would only cost reset fan-out.
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= resp_pc_q;
            mem_data_q[wr_ptr_q] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory requests in flight, oldest first; 'dropped' marks pre-redirect ones.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          dropped;
    } mreq_t;

    typedef struct {
        bit          rn, rr, ir, fl;
        logic [31:0] fp;
        bit          e_rv;
        logic [31:0] e_ra;
        bit          e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    mreq_t       mq[$];
    logic [31:0] fq[$];      // PCs buffered for decode, head first
    logic [31:0] fpc;        // next address the front end should request
    bit          rst_ok;     // one cycle past reset release
    bit          model_on;
    int          lat;
    int          cyc_n;
    int          n_vec;
    int          n_err;
    vec_t        tbl[16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
        end
    endtask

    // Apply one cycle of inputs; the memory answers the oldest due request.
    task automatic drive(input bit rn, input bit rr, input bit ir, input bit fl,
                         input logic [31:0] fp);
        rst_n          = rn;
        imem_req_ready = rr;
        inst_ready     = ir;
        flush          = fl;
        flush_pc       = fp;
        if (rn && mq.size() != 0 && mq[0].due <= cyc_n) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #4;
    endtask

    // Compare outputs against the model, take the edge, advance the model.
    task automatic tick();
        bit    exp_rv;
        bit    exp_iv;
        bit    got;
        mreq_t r;
        exp_rv = rst_ok && !flush && (fq.size() + mq.size() < DEPTH);
        exp_iv = fq.size() != 0;
        if (model_on) begin
            check("m_req_valid", imem_req_valid, exp_rv);
            if (exp_rv) check("m_req_addr", imem_req_addr, fpc);
            check("m_inst_valid", inst_valid, exp_iv);
            if (exp_iv) begin
                check("m_inst_pc", inst_pc, fq[0]);
                check("m_inst_data", inst_data, mem_word(fq[0]));
            end
        end
        @(posedge clk);
        got = 1'b0;
        if (!rst_n) begin
            fq.delete();
            mq.delete();
            fpc    = RESET_PC;
            rst_ok = 1'b0;
        end else begin
            rst_ok = 1'b1;
            if (imem_resp_valid) begin
                r   = mq.pop_front();
                got = !r.dropped;
            end
            if (flush) begin
                fq.delete();
                fpc = {flush_pc[31:2], 2'b00};
                foreach (mq[i]) mq[i].dropped = 1'b1;
            end else begin
                if (exp_rv && imem_req_ready) begin
                    mq.push_back('{fpc, cyc_n + lat, 1'b0});
                    fpc = fpc + 32'd4;
                end
                if (exp_iv && inst_ready) void'(fq.pop_front());
                if (got) fq.push_back(r.addr);
            end
        end
        cyc_n++;
        #1;
    endtask

    task automatic reset_seq();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("post_reset_req_valid", imem_req_valid, 1'b0);
        check("post_reset_inst_valid", inst_valid, 1'b0);
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc_n = 0; lat = 1;
        fpc = RESET_PC; rst_ok = 1'b0; model_on = 1'b0;
        rst_n = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0; flush = 1'b0;
        flush_pc = '0; imem_resp_valid = 1'b0; imem_resp_data = '0;

        // rn rr ir fl fp | req_valid req_addr | inst_valid inst_pc
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h18, 1'b1, 32'h0C};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h14};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h24, 1'b1, 32'h18};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h28, 1'b1, 32'h1C};

        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        model_on = 1'b1;

        // Streaming, then decode back-pressure filling the FIFO, then release
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rn, tbl[i].rr, tbl[i].ir, tbl[i].fl, tbl[i].fp);
            check("t_req_valid", imem_req_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) check("t_req_addr", imem_req_addr, tbl[i].e_ra);
            check("t_inst_valid", inst_valid, tbl[i].e_iv);
            if (tbl[i].e_iv || !tbl[i].rn) check("t_inst_pc", inst_pc, tbl[i].e_ipc);
            tick();
        end

        // Redirect with three requests in flight
        lat = 4;
        reset_seq();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h203);
        check("f3_req_valid_in_flush", imem_req_valid, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("f3_req_valid_after", imem_req_valid, 1'b1);
        check("f3_req_addr_after", imem_req_addr, 32'h200);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            check("f3_no_stale", inst_valid, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("f3_inst_valid", inst_valid, 1'b1);
        check("f3_inst_pc", inst_pc, 32'h200);
        check("f3_inst_data", inst_data, mem_word(32'h200));
        tick();

        // Redirect coinciding with a response and a pop
        lat = 2;
        reset_seq();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1000);
        check("f4_head_before", inst_pc, 32'h0);
        check("f4_resp_present", imem_resp_valid, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("f4_empty_after", inst_valid, 1'b0);
        check("f4_req_addr", imem_req_addr, 32'h1000);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            check("f4_dropped", inst_valid, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("f4_inst_pc", inst_pc, 32'h1000);
        check("f4_inst_data", inst_data, mem_word(32'h1000));
        tick();

        // Stalled request stays stable; address wraps past the top
        lat = 1;
        reset_seq();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            check("w_stall_valid", imem_req_valid, 1'b1);
            check("w_stall_addr", imem_req_addr, 32'hFFFF_FFFC);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("w_wrap_addr", imem_req_addr, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("w_top_pc", inst_pc, 32'hFFFF_FFFC);
        tick();

        // One-cycle reset in the middle of streaming
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("r_inst_valid", inst_valid, 1'b0);
        check("r_req_valid", imem_req_valid, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("r_restart_addr", imem_req_addr, RESET_PC);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("r_restart_pc", inst_pc, RESET_PC);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] fp;
            lat = $urandom_range(1, 4);
            fp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            drive($urandom_range(0, 299) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0, fp);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
